// File: rtl/instr_encoder.sv
// Packs instruction-field requests into 32-bit words and streams them into IMEM through a FIFO.
// Optional request range checking is enabled with `define INSTR_ENCODER_CHECK_EN.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        finish,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cls,
    input  logic [3:0]  req_cond,
    input  logic [3:0]  req_cmd,
    input  logic        req_s,
    input  logic [3:0]  req_rn,
    input  logic [3:0]  req_rd,
    input  logic [11:0] req_src2,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        wrapped,
    output logic [15:0] instr_count,
    output logic        err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   cnt_q;
    logic [IdxW-1:0] idx_q;
    logic            wrapped_q;
    logic [15:0]     count_q;

    logic        fifo_full, fifo_empty, active, accept, push, pop, illegal;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [31:0] word;

    assign fifo_full  = (cnt_q == (PtrW+1)'(DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign active     = (state_q == StRun) || (state_q == StDrain);

    // Requests seen in a start cycle are refused so they cannot survive the flush.
    assign req_ready  = (state_q == StRun) && !fifo_full && !start;
    assign accept     = req_valid && req_ready;
    assign push       = accept && !illegal;

    assign imem_we    = active && !fifo_empty;
    assign pop        = imem_we && imem_ready;
    assign imem_wdata = imem_we ? mem_q[rd_ptr_q] : 32'h0;
    assign imem_addr  = BASE_ADDR + (32'(idx_q) << 2);

    assign busy        = active;
    assign done        = (state_q == StDone);
    assign wrapped     = wrapped_q;
    assign instr_count = count_q;

    always_comb begin
        op    = 2'b00;
        funct = {req_cls[0], req_cmd, req_s};
        unique case (req_cls)
            2'd2: begin
                op    = 2'b01;
                funct = 6'b011000;
            end
            2'd3: begin
                op    = 2'b01;
                funct = 6'b011001;
            end
            default: ;
        endcase
        word = {req_cond, op, funct, req_rn, req_rd, req_src2};
    end

`ifdef INSTR_ENCODER_CHECK_EN
    logic err_q;

    always_comb begin
        illegal = 1'b0;
        if (req_cls == 2'd0 && req_src2[11:4] != 8'h00) begin
            illegal = 1'b1;
        end
        if (req_cls[1] && req_rd == 4'hF && req_rn == 4'hF) begin
            illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && illegal;
        end
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun:   if (finish) state_d = StDrain;
                // Leave DRAIN in the cycle after the final write handshake.
                StDrain: if (fifo_empty || (cnt_q == (PtrW+1)'(1) && pop)) state_d = StDone;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            wrapped_q <= 1'b0;
            count_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            if (start) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                cnt_q     <= '0;
                idx_q     <= '0;
                wrapped_q <= 1'b0;
                count_q   <= 16'h0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                    if (idx_q == IdxW'(MEM_WORDS - 1)) begin
                        idx_q     <= '0;
                        wrapped_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                    if (count_q != 16'hFFFF) begin
                        count_q <= count_q + 16'h1;
                    end
                end
                if (push && !pop) begin
                    cnt_q <= cnt_q + (PtrW+1)'(1);
                end else if (pop && !push) begin
                    cnt_q <= cnt_q - (PtrW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default instance plus a MEM_WORDS=4 instance for wrap checks.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, start, finish, req_valid, imem_ready;
    logic [1:0]  req_cls;
    logic [3:0]  req_cond, req_cmd, req_rn, req_rd;
    logic        req_s;
    logic [11:0] req_src2;

    logic        req_ready, imem_we, busy, done, wrapped, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] instr_count;

    logic        w_req_ready, w_imem_we, w_busy, w_done, w_wrapped, w_err;
    logic [31:0] w_imem_addr, w_imem_wdata;
    logic [15:0] w_instr_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_cls(req_cls), .req_cond(req_cond),
        .req_cmd(req_cmd), .req_s(req_s), .req_rn(req_rn), .req_rd(req_rd), .req_src2(req_src2),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .wrapped(wrapped),
        .instr_count(instr_count), .err(err)
    );

    instr_encoder #(.MEM_WORDS(4)) dut_w (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(w_req_ready), .req_cls(req_cls), .req_cond(req_cond),
        .req_cmd(req_cmd), .req_s(req_s), .req_rn(req_rn), .req_rd(req_rd), .req_src2(req_src2),
        .imem_we(w_imem_we), .imem_ready(imem_ready), .imem_addr(w_imem_addr),
        .imem_wdata(w_imem_wdata), .busy(w_busy), .done(w_done), .wrapped(w_wrapped),
        .instr_count(w_instr_count), .err(w_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [3:0] cond, input logic [3:0] cmd,
                        input logic s, input logic [3:0] rn, input logic [3:0] rd,
                        input logic [11:0] src2);
        req_cls = c; req_cond = cond; req_cmd = cmd; req_s = s;
        req_rn = rn; req_rd = rd; req_src2 = src2;
        req_valid = 1'b1;
    endtask

    // DP-immediate, cond E, cmd D, s 0, rn 0, rd i, src2 i*0x11 -> 0xE3A0_0000 | i<<12 | i*0x11
    function automatic logic [31:0] sw(input int i);
        return 32'hE3A0_0000 | (32'(i) << 12) | 32'(i * 17);
    endfunction

    task automatic send_sw(input int i);
        send(2'd1, 4'hE, 4'hD, 1'b0, 4'h0, 4'(i), 12'(i * 17));
    endtask

    task automatic do_start();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    initial begin
        int j, k;
        logic acc;
        rst = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0; imem_ready = 1'b1;
        req_cls = '0; req_cond = '0; req_cmd = '0; req_s = 1'b0;
        req_rn = '0; req_rd = '0; req_src2 = '0;
        tick(); tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // DP register
        do_start();
        send(2'd0, 4'hE, 4'h4, 1'b0, 4'h1, 4'h2, 12'h003);
        #1 chk("dpr_ready", req_ready, 1);
        chk("dpr_we_before", imem_we, 0);
        tick(); req_valid = 1'b0;
        #1 chk("dpr_we", imem_we, 1);
        chk("dpr_addr", imem_addr, 32'h0);
        chk("dpr_wdata", imem_wdata, 32'hE0812003);

        // start while RUN refuses a concurrent request and flushes
        tick(); start = 1'b1;
        send(2'd0, 4'h1, 4'h1, 1'b1, 4'h1, 4'h1, 12'h001);
        #1 chk("start_ready", req_ready, 0);
        tick(); start = 1'b0; req_valid = 1'b0;
        #1 chk("start_we", imem_we, 0);
        chk("start_count", instr_count, 0);
        chk("start_addr", imem_addr, 32'h0);
        chk("start_busy", busy, 1);

        // back to back: DP imm, LDRV, STRV
        send(2'd1, 4'hE, 4'h2, 1'b1, 4'h3, 4'h3, 12'h001);
        tick(); send(2'd3, 4'hE, 4'h0, 1'b0, 4'h0, 4'h4, 12'h008);
        #1 chk("b2b0_addr", imem_addr, 32'h0);
        chk("b2b0_wdata", imem_wdata, 32'hE2533001);
        tick(); send(2'd2, 4'hE, 4'h0, 1'b0, 4'h0, 4'h4, 12'h008);
        #1 chk("b2b1_addr", imem_addr, 32'h4);
        chk("b2b1_wdata", imem_wdata, 32'hE5904008);
        tick(); req_valid = 1'b0;
        #1 chk("b2b2_addr", imem_addr, 32'h8);
        chk("b2b2_wdata", imem_wdata, 32'hE5804008);
        tick();
        chk("b2b_we_idle", imem_we, 0);
        chk("b2b_count", instr_count, 3);

        // wrap on the 4-word instance: words 4 and 5
        send_sw(9);
        tick(); send_sw(10);
        #1 chk("wrap4_addr", w_imem_addr, 32'hC);
        chk("wrap4_wdata", w_imem_wdata, sw(9));
        chk("wrap4_wrapped", w_wrapped, 0);
        tick(); req_valid = 1'b0;
        #1 chk("wrap5_addr", w_imem_addr, 32'h0);
        chk("wrap5_wdata", w_imem_wdata, sw(10));
        chk("wrap5_wrapped", w_wrapped, 1);
        chk("nowrap_addr", imem_addr, 32'h10);
        chk("nowrap_wrapped", wrapped, 0);
        tick();
        chk("wrap_count", w_instr_count, 5);

        // stall: 10 cycles of imem_ready=0, 6 requests offered
        do_start();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_sw(i);
            #1 chk("stall_ready_hi", req_ready, 1);
            tick();
        end
        send_sw(4);
        for (int c = 0; c < 6; c++) begin
            #1 chk("stall_ready_lo", req_ready, 0);
            chk("stall_we", imem_we, 1);
            chk("stall_addr", imem_addr, 32'h0);
            chk("stall_wdata", imem_wdata, sw(0));
            tick();
        end
        imem_ready = 1'b1;
        j = 0; k = 4;
        for (int c = 0; c < 20 && j < 6; c++) begin
            #1;
            if (imem_we) begin
                chk("drain_addr", imem_addr, 32'(4 * j));
                chk("drain_wdata", imem_wdata, sw(j));
                j++;
            end
            acc = req_valid && req_ready;
            tick();
            if (acc) begin
                k++;
                if (k < 6) send_sw(k);
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("stall_all_written", 32'(j), 6);

        // finish / drain with 3 words buffered
        do_start();
        imem_ready = 1'b0;
        send_sw(0); tick();
        send_sw(1); tick();
        send_sw(2); tick();
        req_valid = 1'b0;
        finish = 1'b1; imem_ready = 1'b1;
        #1 chk("fin_we0", imem_we, 1);
        chk("fin_addr0", imem_addr, 32'h0);
        tick(); finish = 1'b0; send_sw(7);
        #1 chk("fin_ready", req_ready, 0);
        chk("fin_busy", busy, 1);
        chk("fin_addr1", imem_addr, 32'h4);
        tick();
        #1 chk("fin_addr2", imem_addr, 32'h8);
        chk("fin_wdata2", imem_wdata, sw(2));
        chk("fin_done_early", done, 0);
        tick(); req_valid = 1'b0;
        #1 chk("fin_done", done, 1);
        chk("fin_busy_off", busy, 0);
        chk("fin_we_off", imem_we, 0);
        chk("fin_count", instr_count, 3);
        do_start();
        #1 chk("restart_count", instr_count, 0);
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_done", done, 0);

        // reset mid-stream with 2 words buffered
        imem_ready = 1'b0;
        send_sw(0); tick();
        send_sw(1); tick();
        req_valid = 1'b0;
        #1 chk("mid_we", imem_we, 1);
        rst = 1'b1;
        tick(); rst = 1'b0; imem_ready = 1'b1;
        #1 chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", req_ready, 0);
        tick();
        chk("mid_rst_we2", imem_we, 0);

        // shifted DP-register request
        do_start();
        send(2'd0, 4'hE, 4'h4, 1'b0, 4'h1, 4'h2, 12'h0F3);
        tick(); req_valid = 1'b0;
`ifdef INSTR_ENCODER_CHECK_EN
        #1 chk("chk_err", err, 1);
        chk("chk_we", imem_we, 0);
        tick();
        chk("chk_err_pulse", err, 0);
        chk("chk_we2", imem_we, 0);
`else
        #1 chk("chk_err", err, 0);
        chk("chk_we", imem_we, 1);
        chk("chk_wdata", imem_wdata, 32'hE08120F3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
